// File: rtl/proctypes.sv
// Shared processor types: instruction encoding, decoded-instruction record
// and the program sequencer state set.
package proctypes;

    localparam int NUM_INSTRUCTIONS_WIDTH = 4;

    typedef enum logic [2:0] {
        opNop,
        opCameraSet,
        opRender,
        opFrame,
        opUnsupported
    } IType;

    typedef struct packed {
        IType        iType;
        logic [1:0]  sel;
        logic [15:0] data;
    } DecodedInst;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        FRAME_WAIT,
        DONE
    } SeqState;

endpackage

// File: rtl/program_sequencer.sv
// Instruction issue controller: walks the instruction BRAM from pc 0 to
// last_pc, issues each decoded instruction to execute as a one-cycle pulse,
// gates opFrame on a pending display tick and skips unsupported opcodes.
module program_sequencer
    import proctypes::*;
#(
    parameter logic LOOP           = 1'b1,
    parameter int   FRAME_MIN_WAIT = 2
) (
    input  logic                              clk_50mhz,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic                              halt,
    input  logic [NUM_INSTRUCTIONS_WIDTH-1:0] last_pc,
    input  logic                              frame_tick,
    output logic [NUM_INSTRUCTIONS_WIDTH-1:0] instr_addr,
    input  DecodedInst                        dInst_in,
    input  logic                              memory_ready,
    output logic                              dInst_valid,
    output DecodedInst                        dInst,
    output logic [NUM_INSTRUCTIONS_WIDTH-1:0] pc,
    output logic                              busy,
    output logic                              done,
    output logic                              err_unsupported
);

    localparam int          W         = NUM_INSTRUCTIONS_WIDTH;
    // Dwell counter saturates here; leaving FRAME_WAIT is allowed from this value.
    localparam logic [3:0]  WAIT_LAST = 4'(FRAME_MIN_WAIT - 1);

    SeqState        state_q, state_d;
    logic [W-1:0]   pc_q, pc_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           err_q, err_d;
    logic           tick_q, tick_d;
    logic           issue, consume, advance, start_ok;
    logic [W-1:0]   instr_addr_q;
    logic [W-1:0]   pc_iss_q;
    DecodedInst     dInst_q;
    logic           dInst_valid_q, busy_q, done_q;

    // Next-state, pc walk, dwell counter and sticky flags.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        issue    = 1'b0;
        consume  = 1'b0;
        advance  = 1'b0;
        start_ok = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    start_ok = 1'b1;
                    pc_d     = '0;
                    state_d  = FETCH;
                end
            end
            FETCH: begin
                state_d = halt ? IDLE : ISSUE;
            end
            ISSUE: begin
                if (halt) begin
                    state_d = IDLE;
                end else if (dInst_in.iType == opUnsupported) begin
                    err_d   = 1'b1;
                    advance = 1'b1;
                end else if (!memory_ready) begin
                    state_d = ISSUE;
                end else if (dInst_in.iType == opFrame && !tick_q) begin
                    state_d = ISSUE;
                end else begin
                    issue = 1'b1;
                    if (dInst_in.iType == opFrame) begin
                        consume = 1'b1;
                        cnt_d   = '0;
                        state_d = FRAME_WAIT;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            FRAME_WAIT: begin
                if (halt) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == WAIT_LAST) begin
                    if (memory_ready) begin
                        cnt_d   = '0;
                        advance = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Compare with >= so a last_pc lowered mid-run still terminates the walk.
        if (advance) begin
            if (pc_q >= last_pc) begin
                if (LOOP) begin
                    pc_d    = '0;
                    state_d = FETCH;
                end else begin
                    state_d = DONE;
                end
            end else begin
                pc_d    = pc_q + 1'b1;
                state_d = FETCH;
            end
        end

        if (start_ok) begin
            err_d = 1'b0;
        end

        // A tick arriving in the same cycle as a consume or start wins.
        tick_d = frame_tick | (tick_q & ~consume & ~start_ok);
    end

    // State, control flags and registered outputs.
    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= '0;
            cnt_q         <= '0;
            err_q         <= 1'b0;
            tick_q        <= 1'b0;
            instr_addr_q  <= '0;
            pc_iss_q      <= '0;
            dInst_q       <= '0;
            dInst_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            cnt_q         <= cnt_d;
            err_q         <= err_d;
            tick_q        <= tick_d;
            instr_addr_q  <= pc_d;
            dInst_valid_q <= issue;
            busy_q        <= (state_d == FETCH) || (state_d == ISSUE) || (state_d == FRAME_WAIT);
            done_q        <= (state_d == DONE);
            if (issue) begin
                dInst_q  <= dInst_in;
                pc_iss_q <= pc_q;
            end
        end
    end

    assign instr_addr      = instr_addr_q;
    assign dInst_valid     = dInst_valid_q;
    assign dInst           = dInst_q;
    assign pc              = pc_iss_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign err_unsupported = err_q;

endmodule
